// File: rtl/ps2_kbd_fifo_intc.sv
// rtl/ps2_kbd_fifo_intc.sv - PS/2 keyboard receiver with scan-code FIFO and interrupt/ack handshake
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity check on received frames)
// The interrupt request port is named int_req because "int" is a reserved word in SystemVerilog.
module ps2_kbd_fifo_intc #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          intAck,
    output logic [7:0]                    code,
    output logic                          int_req,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          perr
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYC);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nx;
    logic            clk_s1, clk_s2, clk_s3;
    logic            dat_s1, dat_s2;
    logic            fall;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            par_ok;
    logic            frame_good, frame_bad;
    logic [WDW-1:0]  wd_cnt;
    logic            push_req;
    logic [7:0]      push_byte;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [CW-1:0]   wr_ptr, rd_ptr;
    logic            full, empty, push, pop, drop, wr_en;

    // Two-stage synchronisers plus a third ps2_clk stage used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    // Data plus parity must contain an odd number of ones
    assign par_ok = ^{shreg, par_bit};
`else
    // Parity bit is captured but has no influence on frame acceptance
    assign par_ok = 1'b1 | par_bit;
`endif

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Receiver next-state and frame verdict; a stalled frame is abandoned silently
    always_comb begin
        state_nx   = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nx = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (dat_s2 && par_ok) frame_good = 1'b1;
                    else                  frame_bad  = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && wd_cnt == WD_MAX) begin
            state_nx = IDLE;
        end
    end

    // Frame watchdog: restarts on every falling edge, runs only inside a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          wd_cnt <= '0;
        else if (fall || state == IDLE)   wd_cnt <= '0;
        else if (wd_cnt != WD_MAX)        wd_cnt <= wd_cnt + 1'b1;
    end

    // Bit counter, LSB-first shift register and parity capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE:    bit_cnt <= '0;
                DATA: begin
                    shreg   <= {dat_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY:  par_bit <= dat_s2;
                default: ;
            endcase
        end
    end

    // Frame verdict is registered: push request and perr appear the cycle after the stop edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_req  <= 1'b0;
            push_byte <= '0;
            perr      <= 1'b0;
        end else begin
            push_req  <= frame_good;
            push_byte <= shreg;
            perr      <= frame_bad;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = ~int_req & ~intAck & ~empty;
    assign push  = push_req;
    assign drop  = push & full & ~pop;
    assign wr_en = push & ~drop;

    // FIFO storage; when full with a simultaneous pop the head is read before being overwritten
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_byte;
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Interrupt handshake: offer one byte, hold it until acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_req <= 1'b0;
            code    <= '0;
        end else if (int_req) begin
            if (intAck) int_req <= 1'b0;
        end else if (pop) begin
            int_req <= 1'b1;
            code    <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Sticky overflow; a drop in the acknowledging cycle wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    overflow <= 1'b0;
        else if (drop)              overflow <= 1'b1;
        else if (intAck && int_req) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_ps2_kbd_fifo_intc.sv
// tb/tb_ps2_kbd_fifo_intc.sv - scoreboard testbench for ps2_kbd_fifo_intc
module tb_ps2_kbd_fifo_intc;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       intAck = 1'b0;
    logic [7:0] code;
    logic       int_req;
    logic [3:0] count;
    logic       overflow;
    logic       perr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_code;
    int         perr_pulses = 0;
    int         perr_cycles = 0;
    int         exp_perr = 0;
    logic       int_prev = 1'b0;
    logic       perr_prev = 1'b0;

    always #10 clk = ~clk;

    ps2_kbd_fifo_intc #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .intAck   (intAck),
        .code     (code),
        .int_req  (int_req),
        .count    (count),
        .overflow (overflow),
        .perr     (perr)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every new interrupt must present the next scoreboard byte
    always @(negedge clk) begin
        if (int_req && !int_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_int: got code %0h expected no interrupt", code);
            end else begin
                exp_code = exp_q.pop_front();
                if (code != exp_code) begin
                    errors++;
                    $display("FAIL int_code: got %0h expected %0h", code, exp_code);
                end
            end
        end
        if (perr) perr_cycles++;
        if (perr && !perr_prev) perr_pulses++;
        int_prev  = int_req;
        perr_prev = perr;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
    endtask

    task automatic ack_once();
        intAck = 1'b1;
        @(negedge clk);
        chk("int_clear_after_ack", int_req, 0);
        intAck = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_code", code, 0);
        chk("rst_int", int_req, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_perr", perr, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single frame, held then acknowledged
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("single_int", int_req, 1);
        chk("single_count", count, 0);
        ack_once();
        repeat (3) @(negedge clk);
        chk("single_int_stays_low", int_req, 0);

        // two frames queued behind a held interrupt
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("two_code", code, 8'hF0);
        chk("two_count", count, 1);
        ack_once();
        chk("two_next_int", int_req, 1);
        chk("two_next_code", code, 8'h1C);
        ack_once();

        // overflow: 10 frames with no ack, last one dropped
        for (int b = 1; b <= 10; b++) begin
            if (b <= 9) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b0, 1'b0);
        end
        chk("ovf_code", code, 8'h01);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        for (int k = 0; k < 8; k++) begin
            ack_once();
            if (k == 0) chk("ovf_cleared", overflow, 0);
            chk("ovf_seq_code", code, k + 2);
        end
        chk("ovf_drained", count, 0);
        ack_once();
        repeat (3) @(negedge clk);
        chk("ovf_idle", int_req, 0);

        // wrong parity
`ifdef PS2_PARITY_CHECK_EN
        exp_perr++;
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("par_int", int_req, 0);
        chk("par_count", count, 0);
`else
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("par_ignored_int", int_req, 1);
        ack_once();
`endif

        // bad stop bit always drops the frame
        exp_perr++;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("stop_int", int_req, 0);
        chk("stop_count", count, 0);

        // watchdog aborts a stalled frame without perr
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        repeat (TMO + 10) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("wd_int", int_req, 1);
        chk("wd_count", count, 0);
        ack_once();

        // reset mid-frame with a held interrupt and three buffered bytes
        exp_q.push_back(8'h11);
        for (int b = 8'h11; b <= 8'h14; b++) send_frame(8'(b), 1'b0, 1'b0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_int", int_req, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_int", int_req, 0);
        chk("mid_rst_code", code, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b0);
        chk("post_rst_int", int_req, 1);
        chk("post_rst_code", code, 8'h33);
        ack_once();
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("perr_pulses", perr_pulses, exp_perr);
        chk("perr_cycles", perr_cycles, exp_perr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
